j1_uart: RTL and testbench
==========================

# j1_uart

Memory-mapped 8N1 UART peripheral on the J1 data bus, directly downstream of the core's data-bus port. It decodes a 4-word register window, buffers transmit and receive bytes in FIFOs, serialises and deserialises at a programmable bit period, and returns read data with the single-cycle registered latency the core expects (strobe in cycle N, data consumed in N+1).

## Interface
- `BASE`, 16'h3FF0: word address of register 0; bits [1:0] must be zero. Window is `BASE`..`BASE+3`.
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO; power of two, 2..256.
- `DIV_RESET`, 16'd433: reset value of the divisor register. Bit period = divisor+1 clocks.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `dbus`  if_dbus.slave  —  `adr[15:0]` word address, `re`/`we` single-cycle strobes, `dat_o[15:0]` write data from core, `dat_i[15:0]` read data to core.
- `uart_rxd`  in  1  serial input, asynchronous.
- `uart_txd`  out  1  serial output, idle high.
- `irq`  out  1  high while RX FIFO non-empty.

## Operation
- Select: `hit = (adr[15:2] == BASE[15:2])`; offset = `adr[1:0]`. Strobes without `hit` are ignored.
- Offset 0 DATA: write pushes `dat_o[7:0]` into TX FIFO (dropped if full). Read returns `{rx_valid,7'b0,byte}` and pops RX FIFO; if RX empty returns 16'h0000, no pop.
- Offset 1 STATUS (read-only): [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_busy, [5] frame_err, others 0. Reading STATUS clears bits 3 and 5 (sticky otherwise).
- Offset 2 DIVISOR: read/write, 16 bit. Values below 3 behave as 3.
- Offset 3: reads 0, writes ignored.
- `dat_i` is registered; it is 0 after a cycle whose `re` did not hit, so the parent may OR slave responses.
- TX FSM: IDLE → START (txd=0) → DATA×8 (LSB first) → STOP (txd=1) → IDLE or START if FIFO non-empty. Each state lasts one bit period.
- RX: 2-FF synchroniser. IDLE detects falling edge → START waits half period; if line high again → IDLE (false start). DATA samples 8 bits at full-period intervals. STOP: high → push byte; low → frame_err set, byte discarded, wait for line high before IDLE.
- RX push into full FIFO: byte dropped, rx_overrun set.
- Simultaneous RX pop and push: both take effect; a push into a full FIFO in the same cycle as a pop is accepted.
- DIVISOR write mid-frame: takes effect at the next bit boundary of each FSM.

## Timing
- Reset values: `uart_txd`=1, `irq`=0, `dat_i`=0, divisor=`DIV_RESET`, FIFOs empty, status sticky bits 0, both FSMs IDLE.
- Read: `re` in cycle N → `dat_i` valid from N+1, held until next `re` edge; pop/clear visible from N+1.
- Write: `we` in N → FIFO/register updated at N+1; idle transmitter drives start bit from N+2.
- RX: byte visible in FIFO (and `irq` high) 1 cycle after mid-stop-bit sample.
- `reset_n` asserted mid-frame: immediate return to reset values, frame lost; no glitch low on `uart_txd`.

## Structure
- Shared package `uart_pkg`: register offset constants, STATUS bit indices, `tx_state_t`/`rx_state_t` enums.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count, first-word-fall-through), instantiated twice.
- Bit-period counters local to each FSM.

## Test plan
- Reset, read STATUS → `dat_i`=16'h0002 in the following cycle; `uart_txd`=1.
- DIVISOR=3, write DATA 16'h00A5 → txd low from N+2, bits 1,0,1,0,0,1,0,1 each 4 clocks, stop high.
- Drive 8N1 byte 16'h3C on `uart_rxd` at period 4 → `irq`=1; read DATA → 16'h803C; next STATUS read → rx_valid=0, `irq`=0.
- Receive FIFO_DEPTH+1 bytes without reading → STATUS bit3=1; reading STATUS twice → second shows bit3=0; first FIFO byte intact.
- Stop bit driven low → frame_err=1, no push; 1-period low glitch on idle rxd → no byte, no error.
- Write 17 bytes back-to-back with TX idle → exactly 17 frames transmitted? No: first byte starts immediately, 16 fill FIFO, all 17 sent in order; 18th write when full is dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the j1_uart peripheral.
//   Register offsets within the 4-word window, STATUS bit positions,
//   TX/RX state enums and the effective-divisor helper.
package uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_VALID   = 2;
    localparam int unsigned ST_RX_OVERRUN = 3;
    localparam int unsigned ST_TX_BUSY    = 4;
    localparam int unsigned ST_FRAME_ERR  = 5;

    localparam logic [15:0] DIV_MIN = 16'd3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // Divisors below DIV_MIN are clamped so a bit always spans >= 4 clocks.
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/if_dbus.sv
// if_dbus: J1 data-bus connection.
//   adr   word address          re/we  single-cycle strobes
//   dat_o write data from core  dat_i  read data to core
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport slave  (input adr, re, we, dat_o, output dat_i);
    modport master (output adr, re, we, dat_o, input dat_i);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   i_push/i_din  write side       i_pop          read side (o_dout valid when !o_empty)
//   o_full/o_empty/o_count         occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/j1_uart.sv
// j1_uart: memory-mapped 8N1 UART on the J1 data bus.
//   clk, reset_n   clock, async active-low reset
//   dbus           bus slave: DATA(0) STATUS(1) DIVISOR(2) reserved(3) at BASE..BASE+3
//   uart_rxd       async serial in      uart_txd  serial out, idle high
//   irq            high while RX FIFO holds data
import uart_pkg::*;

module j1_uart #(
    parameter logic [15:0]  BASE       = 16'h3FF0,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter logic [15:0]  DIV_RESET  = 16'd433
) (
    input  logic  clk,
    input  logic  reset_n,
    if_dbus.slave dbus,
    input  logic  uart_rxd,
    output logic  uart_txd,
    output logic  irq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            w_hit, w_rd, w_wr, w_st_clr;
    logic [1:0]      w_off;
    logic [15:0]     r_dat_i, w_rd_val, w_status, r_div, w_div_eff;
    logic            r_overrun, r_frame_err, w_overrun_set, w_ferr_set;

    logic            w_tx_push, w_tx_pop, w_txf_full, w_txf_empty;
    logic [7:0]      w_txf_dout;
    logic [CW-1:0]   w_txf_count;
    logic            w_rx_push, w_rx_pop, w_rxf_full, w_rxf_empty;
    logic [7:0]      w_rxf_dout;
    logic [CW-1:0]   w_rxf_count;

    tx_state_t       r_tx_state, w_tx_state_n;
    logic [15:0]     r_tx_cnt, w_tx_cnt_n;
    logic [2:0]      r_tx_bit, w_tx_bit_n;
    logic [7:0]      r_tx_sh, w_tx_sh_n;
    logic            r_txd, w_txd_n, w_tx_tick;

    rx_state_t       r_rx_state, w_rx_state_n;
    logic [15:0]     r_rx_cnt, w_rx_cnt_n;
    logic [2:0]      r_rx_bit, w_rx_bit_n;
    logic [7:0]      r_rx_sh, w_rx_sh_n;
    logic            r_rx_s1, r_rx_s2, r_rx_prev, w_rx_tick;

    // ---------------- bus decode and registers ----------------
    assign w_hit     = (dbus.adr[15:2] == BASE[15:2]);
    assign w_off     = dbus.adr[1:0];
    assign w_rd      = dbus.re && w_hit;
    assign w_wr      = dbus.we && w_hit;
    assign w_st_clr  = w_rd && (w_off == OFF_STATUS);
    assign w_tx_push = w_wr && (w_off == OFF_DATA) && !w_txf_full;
    assign w_rx_pop  = w_rd && (w_off == OFF_DATA) && !w_rxf_empty;
    assign w_overrun_set = w_rx_push && w_rxf_full && !w_rx_pop;
    assign w_div_eff = div_eff(r_div);
    assign dbus.dat_i = r_dat_i;
    assign irq       = (w_rxf_count != '0);
    assign uart_txd  = r_txd;

    always_comb begin
        w_status                = '0;
        w_status[ST_TX_FULL]    = w_txf_full;
        w_status[ST_TX_EMPTY]   = (w_txf_count == '0);
        w_status[ST_RX_VALID]   = !w_rxf_empty;
        w_status[ST_RX_OVERRUN] = r_overrun;
        w_status[ST_TX_BUSY]    = (r_tx_state != TX_IDLE);
        w_status[ST_FRAME_ERR]  = r_frame_err;
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            OFF_DATA:   if (!w_rxf_empty) w_rd_val = {1'b1, 7'b0, w_rxf_dout};
            OFF_STATUS: w_rd_val = w_status;
            OFF_DIV:    w_rd_val = r_div;
            default:    w_rd_val = '0;
        endcase
    end

    // dat_i only changes on a read strobe; a non-hitting read returns 0
    // so sibling slaves can be OR-ed together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dat_i     <= '0;
            r_div       <= DIV_RESET;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (dbus.re) r_dat_i <= w_hit ? w_rd_val : '0;
            if (w_wr && (w_off == OFF_DIV)) r_div <= dbus.dat_o;
            if (w_overrun_set) r_overrun <= 1'b1;
            else if (w_st_clr) r_overrun <= 1'b0;
            if (w_ferr_set) r_frame_err <= 1'b1;
            else if (w_st_clr) r_frame_err <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(clk), .i_rst_n(reset_n), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_din(dbus.dat_o[7:0]), .o_dout(w_txf_dout), .o_full(w_txf_full),
        .o_empty(w_txf_empty), .o_count(w_txf_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(clk), .i_rst_n(reset_n), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_din(r_rx_sh), .o_dout(w_rxf_dout), .o_full(w_rxf_full),
        .o_empty(w_rxf_empty), .o_count(w_rxf_count)
    );

    // ---------------- transmitter ----------------
    // The bit counter is reloaded from the divisor at every bit boundary,
    // so a divisor write mid-frame applies from the next bit onward.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_sh_n    = r_tx_sh;
        w_txd_n      = r_txd;
        w_tx_pop     = 1'b0;
        w_tx_tick    = (r_tx_cnt == '0);
        if (r_tx_state != TX_IDLE && !w_tx_tick) w_tx_cnt_n = r_tx_cnt - 16'd1;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd_n = 1'b1;
                if (!w_txf_empty) begin
                    w_tx_pop = 1'b1; w_tx_sh_n = w_txf_dout; w_txd_n = 1'b0;
                    w_tx_cnt_n = w_div_eff; w_tx_state_n = TX_START;
                end
            end
            TX_START: if (w_tx_tick) begin
                w_tx_state_n = TX_DATA; w_tx_bit_n = '0;
                w_txd_n = r_tx_sh[0]; w_tx_cnt_n = w_div_eff;
            end
            TX_DATA: if (w_tx_tick) begin
                w_tx_cnt_n = w_div_eff;
                if (r_tx_bit == 3'd7) begin
                    w_tx_state_n = TX_STOP; w_txd_n = 1'b1;
                end else begin
                    w_tx_bit_n = r_tx_bit + 3'd1;
                    w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                    w_txd_n    = r_tx_sh[1];
                end
            end
            TX_STOP: if (w_tx_tick) begin
                if (!w_txf_empty) begin
                    w_tx_pop = 1'b1; w_tx_sh_n = w_txf_dout; w_txd_n = 1'b0;
                    w_tx_cnt_n = w_div_eff; w_tx_state_n = TX_START;
                end else begin
                    w_txd_n = 1'b1; w_tx_state_n = TX_IDLE;
                end
            end
            default: begin w_tx_state_n = TX_IDLE; w_txd_n = 1'b1; end
        endcase
    end

    // txd is a flop so reset and state changes never glitch the line low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE; r_tx_cnt <= '0; r_tx_bit <= '0;
            r_tx_sh <= '0; r_txd <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n; r_tx_cnt <= w_tx_cnt_n; r_tx_bit <= w_tx_bit_n;
            r_tx_sh <= w_tx_sh_n; r_txd <= w_txd_n;
        end
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_sh_n    = r_rx_sh;
        w_rx_push    = 1'b0;
        w_ferr_set   = 1'b0;
        w_rx_tick    = (r_rx_cnt == '0);
        if (r_rx_state inside {RX_START, RX_DATA, RX_STOP} && !w_rx_tick)
            w_rx_cnt_n = r_rx_cnt - 16'd1;
        case (r_rx_state)
            RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
                w_rx_state_n = RX_START; w_rx_cnt_n = w_div_eff >> 1;
            end
            RX_START: if (w_rx_tick) begin
                if (r_rx_s2) w_rx_state_n = RX_IDLE;
                else begin
                    w_rx_state_n = RX_DATA; w_rx_bit_n = '0; w_rx_cnt_n = w_div_eff;
                end
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                w_rx_cnt_n = w_div_eff;
                if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                else w_rx_bit_n = r_rx_bit + 3'd1;
            end
            RX_STOP: if (w_rx_tick) begin
                if (r_rx_s2) begin
                    w_rx_push = 1'b1; w_rx_state_n = RX_IDLE;
                end else begin
                    w_ferr_set = 1'b1; w_rx_state_n = RX_WAIT;
                end
            end
            RX_WAIT: if (r_rx_s2) w_rx_state_n = RX_IDLE;
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
        end else begin
            r_rx_state <= w_rx_state_n; r_rx_cnt <= w_rx_cnt_n;
            r_rx_bit <= w_rx_bit_n; r_rx_sh <= w_rx_sh_n;
        end
    end
endmodule

// File: tb/tb_j1_uart.sv
// tb_j1_uart: directed self-checking bench for j1_uart.
module tb_j1_uart;
    logic clk = 1'b0;
    logic reset_n;
    logic uart_rxd;
    logic uart_txd;
    logic irq;
    int   n_total = 0;
    int   n_bad   = 0;

    localparam logic [15:0] A_DATA = 16'h3FF0;
    localparam logic [15:0] A_STAT = 16'h3FF1;
    localparam logic [15:0] A_DIV  = 16'h3FF2;
    localparam logic [15:0] A_RSVD = 16'h3FF3;

    if_dbus bus();

    j1_uart #(.BASE(16'h3FF0), .FIFO_DEPTH(16), .DIV_RESET(16'd433)) dut (
        .clk(clk), .reset_n(reset_n), .dbus(bus),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.adr = a; bus.dat_o = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.adr = a; bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        d = bus.dat_i;
    endtask

    task automatic rx_bit(input logic v);
        uart_rxd = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Receives one frame at a 4-clock bit period, sampling mid-bit.
    task automatic tx_capture(output logic [7:0] b);
        int t;
        t = 0;
        b = '0;
        while (uart_txd !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_wait_start", 16'(uart_txd), 16'h0000);
        repeat (2) @(negedge clk);
        check("tx_startbit", 16'(uart_txd), 16'h0000);
        for (int k = 0; k < 8; k++) begin
            repeat (4) @(negedge clk);
            b[k] = uart_txd;
        end
        repeat (4) @(negedge clk);
        check("tx_stopbit", 16'(uart_txd), 16'h0001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] d, d_st;
        logic [9:0]  frame;
        logic [7:0]  b;
        logic [7:0]  cap [17];
        int          lows;

        reset_n = 1'b0; uart_rxd = 1'b1;
        bus.re = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_o = '0;
        repeat (3) @(negedge clk);
        check("rst_txd",  16'(uart_txd), 16'h0001);
        check("rst_irq",  16'(irq),      16'h0000);
        check("rst_dati", bus.dat_i,     16'h0000);
        reset_n = 1'b1;

        bus_rd(A_STAT, d); check("rst_status", d, 16'h0002);
        bus_rd(A_DIV, d);  check("rst_div", d, 16'd433);
        bus_rd(16'h0001, d); check("miss_read", d, 16'h0000);

        bus_wr(A_DIV, 16'd3);
        bus_rd(A_DIV, d); check("div_rb", d, 16'd3);

        // 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop; each bit 4 clocks
        bus_wr(A_DATA, 16'h00A5);
        check("tx_n1_idle", 16'(uart_txd), 16'h0001);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check($sformatf("tx_a5_bit%0d", k), 16'(uart_txd), 16'(frame[k]));
            end
        repeat (2) @(negedge clk);
        check("tx_after_idle", 16'(uart_txd), 16'h0001);

        rx_send(8'h3C, 1'b1);
        check("rx_irq_set", 16'(irq), 16'h0001);
        bus_rd(A_DATA, d); check("rx_data_3c", d, 16'h803C);
        bus_rd(A_STAT, d); check("rx_status_empty", d, 16'h0002);
        check("rx_irq_clr", 16'(irq), 16'h0000);

        rx_send(8'h55, 1'b0);
        check("ferr_irq", 16'(irq), 16'h0000);
        bus_rd(A_STAT, d); check("ferr_status", d, 16'h0022);
        bus_rd(A_STAT, d); check("ferr_cleared", d, 16'h0002);

        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_irq", 16'(irq), 16'h0000);
        bus_rd(A_STAT, d); check("glitch_status", d, 16'h0002);

        for (int i = 0; i < 17; i++) rx_send(8'h40 + 8'(i), 1'b1);
        bus_rd(A_STAT, d); check("ovr_status", d, 16'h000E);
        bus_rd(A_STAT, d); check("ovr_cleared", d, 16'h0006);
        for (int i = 0; i < 16; i++) begin
            bus_rd(A_DATA, d);
            check($sformatf("ovr_data%0d", i), d, 16'h8040 + 16'(i));
        end
        bus_rd(A_DATA, d); check("rx_empty_read", d, 16'h0000);
        check("ovr_irq_clr", 16'(irq), 16'h0000);

        bus_wr(A_RSVD, 16'hFFFF);
        bus_rd(A_RSVD, d); check("rsvd_read", d, 16'h0000);
        bus_rd(A_DIV, d);  check("rsvd_no_side", d, 16'd3);

        // 18 back-to-back writes: 1 goes straight out, 16 fill the FIFO, 18th dropped
        fork
            begin
                @(negedge clk);
                bus.adr = A_DATA; bus.we = 1'b1;
                for (int i = 0; i < 18; i++) begin
                    bus.dat_o = 16'h0010 + 16'(i);
                    @(negedge clk);
                end
                bus.we = 1'b0;
                bus_rd(A_STAT, d_st);
                check("tx_full_status", d_st, 16'h0011);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    tx_capture(b);
                    cap[i] = b;
                end
            end
        join
        for (int i = 0; i < 17; i++)
            check($sformatf("tx_order%0d", i), 16'(cap[i]), 16'h0010 + 16'(i));
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        check("tx_no_extra", 16'(lows), 16'h0000);
        bus_rd(A_STAT, d); check("tx_done_status", d, 16'h0002);

        // divisor 0 must behave as 3 (4-clock bits)
        bus_wr(A_DIV, 16'd0);
        bus_wr(A_DATA, 16'h005A);
        tx_capture(b);
        check("div0_byte", 16'(b), 16'h005A);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
